intr_ctrl: RTL and testbench

Parametrised multi-source interrupt controller that replaces the CPU's single interrupt request line. It latches rising edges from `NUM_SRC` peripheral sources into a pending register and applies a per-source mask. It arbitrates among enabled pending sources and presents one request, with its computed vector, to the CPU core. Sits between the peripherals (UART rx/tx, timers) and the core's interrupt inputs: `irr` and `intr_vec` in, `intr_en`, `ack` and end-of-interrupt out of the core.

---
 rtl/intr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_intr_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: edge-latched pending bits, per-source mask, single request to the core.
// Define INTR_CTRL_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module intr_ctrl #(
    parameter int unsigned    NUM_SRC    = 4,
    parameter logic [31:0]    VEC_BASE   = 32'h0000_0100,
    parameter int unsigned    VEC_STRIDE = 16,
    localparam int unsigned   ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               intr_en,
    input  logic               ack,
    input  logic               eoi,
    output logic               irr,
    output logic [31:0]        intr_vec,
    output logic [ID_W-1:0]    src_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERV
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_irr;
    logic               r_busy;
    logic [ID_W-1:0]    r_src_id;
    logic [31:0]        r_intr_vec;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_elig;
    logic [ID_W-1:0]    w_win;
    logic               w_found;
    logic [31:0]        w_vec;
    logic               w_irr_nxt;
    logic               w_busy_nxt;
    logic               w_grant;

    assign w_rise = irq_src & ~r_irq_prev;
    assign w_elig = r_pending & r_mask;
    assign w_vec  = VEC_BASE + (32'(w_win) * VEC_STRIDE);

`ifdef INTR_CTRL_RR_EN
    logic [ID_W-1:0] r_last_id;

    // Search above last_id first, then wrap to the lowest index: same as starting at last_id+1 mod NUM_SRC.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!w_found && w_elig[i] && (i > 32'(r_last_id))) begin
                w_win   = ID_W'(i);
                w_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!w_found && w_elig[i]) begin
                w_win   = ID_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_id <= ID_W'(NUM_SRC - 1);
        end else if ((r_state == ST_REQ) && ack) begin
            r_last_id <= r_src_id;
        end
    end
`else
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!w_found && w_elig[i]) begin
                w_win   = ID_W'(i);
                w_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_irr_nxt   = r_irr;
        w_busy_nxt  = r_busy;
        w_grant     = 1'b0;
        w_clr       = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (intr_en && w_found) begin
                    w_grant     = 1'b1;
                    w_irr_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    w_clr       = NUM_SRC'(1) << r_src_id;
                    w_irr_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SERV;
                end else if (!intr_en) begin
                    w_irr_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (eoi) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_irr_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '1;
            r_irr      <= 1'b0;
            r_busy     <= 1'b0;
            r_src_id   <= '0;
            r_intr_vec <= VEC_BASE;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_prev <= irq_src;
            // Set after clear so a new edge in the ack cycle is kept.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_irr      <= w_irr_nxt;
            r_busy     <= w_busy_nxt;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_grant) begin
                r_src_id   <= w_win;
                r_intr_vec <= w_vec;
            end
        end
    end

    assign irr      = r_irr;
    assign intr_vec = r_intr_vec;
    assign src_id   = r_src_id;
    assign pending  = r_pending;
    assign busy     = r_busy;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_intr_ctrl;

    localparam int          NS = 4;
    localparam logic [31:0] VB = 32'h0000_0100;
    localparam int          VS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] irq_src = '0;
    logic          mask_we = 1'b0;
    logic [NS-1:0] mask_wdata = '0;
    logic          intr_en = 1'b0;
    logic          ack = 1'b0;
    logic          eoi = 1'b0;
    logic          irr;
    logic [31:0]   intr_vec;
    logic [1:0]    src_id;
    logic [NS-1:0] pending;
    logic          busy;

    int total = 0;
    int bad   = 0;

    intr_ctrl #(
        .NUM_SRC   (NS),
        .VEC_BASE  (VB),
        .VEC_STRIDE(VS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .intr_en   (intr_en),
        .ack       (ack),
        .eoi       (eoi),
        .irr       (irr),
        .intr_vec  (intr_vec),
        .src_id    (src_id),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural reference: request/in-service flags and plain bit arithmetic.
    logic [NS-1:0] m_prev, m_pend, m_mask;
    logic          m_irr, m_busy;
    logic [1:0]    m_id;
    logic [31:0]   m_vec;
`ifdef INTR_CTRL_RR_EN
    logic [1:0]    m_last;
`endif

    function automatic logic [1:0] pick(input logic [NS-1:0] e, input int start);
        for (int k = 0; k < NS; k++) begin
            int c;
            c = (start + k) % NS;
            if (e[c]) return 2'(c);
        end
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : ref_model
        logic [NS-1:0] rise, clr, elig;
        logic [1:0]    w;
        int            start;
        if (!rst_n) begin
            m_prev <= '0;
            m_pend <= '0;
            m_mask <= '1;
            m_irr  <= 1'b0;
            m_busy <= 1'b0;
            m_id   <= 2'd0;
            m_vec  <= VB;
`ifdef INTR_CTRL_RR_EN
            m_last <= 2'(NS - 1);
`endif
        end else begin
            rise = irq_src & ~m_prev;
            clr  = '0;
            elig = m_pend & m_mask;
`ifdef INTR_CTRL_RR_EN
            start = (int'(m_last) + 1) % NS;
`else
            start = 0;
`endif
            if (m_busy) begin
                if (eoi) m_busy <= 1'b0;
            end else if (m_irr) begin
                if (ack) begin
                    clr[m_id] = 1'b1;
                    m_irr  <= 1'b0;
                    m_busy <= 1'b1;
`ifdef INTR_CTRL_RR_EN
                    m_last <= m_id;
`endif
                end else if (!intr_en) begin
                    m_irr <= 1'b0;
                end
            end else if (intr_en && (elig != '0)) begin
                w = pick(elig, start);
                m_id  <= w;
                m_vec <= VB + 32'(w) * VS;
                m_irr <= 1'b1;
            end
            m_pend <= (m_pend & ~clr) | rise;
            m_prev <= irq_src;
            if (mask_we) m_mask <= mask_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL reset_irr got=%b exp=0", irr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (src_id !== 2'd0) begin bad++; $display("FAIL reset_src_id got=%0d exp=0", src_id); end
        total++; if (intr_vec !== VB) begin bad++; $display("FAIL reset_vec got=%h exp=%h", intr_vec, VB); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        intr_en = 1'b1;
        irq_src = 4'b0100;
        tick();
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending got=%b exp=0100", pending); end
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL single_irr_early got=%b exp=0", irr); end
        tick();
        total++; if (irr !== 1'b1) begin bad++; $display("FAIL single_irr got=%b exp=1", irr); end
        total++; if (src_id !== 2'd2) begin bad++; $display("FAIL single_src_id got=%0d exp=2", src_id); end
        total++; if (intr_vec !== 32'h120) begin bad++; $display("FAIL single_vec got=%h exp=00000120", intr_vec); end
        pulse_ack();
        total++; if ({irr, busy, pending} !== {1'b0, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL single_ack got irr=%b busy=%b pend=%b exp irr=0 busy=1 pend=0000", irr, busy, pending);
        end
        pulse_eoi();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_eoi_busy got=%b exp=0", busy); end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_priority();
        irq_src = 4'b1010;
        tick();
        tick();
        total++; if ({irr, src_id} !== {1'b1, 2'd1}) begin bad++; $display("FAIL prio_first got irr=%b id=%0d exp irr=1 id=1", irr, src_id); end
        pulse_ack();
        pulse_eoi();
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL b2b_gap got irr=%b exp=0", irr); end
        tick();
        total++; if ({irr, src_id, intr_vec} !== {1'b1, 2'd3, 32'h130}) begin
            bad++; $display("FAIL prio_second got irr=%b id=%0d vec=%h exp irr=1 id=3 vec=00000130", irr, src_id, intr_vec);
        end
        pulse_ack();
        pulse_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq_src = 4'b0001;
        tick();
        total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL mask_pending0 got=%b exp=1", pending[0]); end
        tick();
        tick();
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL mask_blocked got irr=%b exp=0", irr); end
        mask_we = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL mask_write_edge got irr=%b exp=0", irr); end
        tick();
        total++; if ({irr, src_id} !== {1'b1, 2'd0}) begin bad++; $display("FAIL mask_unblock got irr=%b id=%0d exp irr=1 id=0", irr, src_id); end
        pulse_ack();
        pulse_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_intr_en_drop();
        irq_src = 4'b0100;
        tick();
        tick();
        intr_en = 1'b0;
        tick();
        total++; if ({irr, pending[2]} !== 2'b01) begin bad++; $display("FAIL en_drop got irr=%b pend2=%b exp irr=0 pend2=1", irr, pending[2]); end
        tick();
        total++; if (irr !== 1'b0) begin bad++; $display("FAIL en_drop_hold got irr=%b exp=0", irr); end
        intr_en = 1'b1;
        tick();
        total++; if ({irr, src_id} !== {1'b1, 2'd2}) begin bad++; $display("FAIL en_rerequest got irr=%b id=%0d exp irr=1 id=2", irr, src_id); end
        pulse_ack();
        pulse_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_ack_edge();
        irq_src = 4'b0100;
        tick();
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100;
        pulse_ack();
        total++; if ({irr, busy, pending} !== {1'b0, 1'b1, 4'b0100}) begin
            bad++; $display("FAIL ack_edge got irr=%b busy=%b pend=%b exp irr=0 busy=1 pend=0100", irr, busy, pending);
        end
        pulse_eoi();
        tick();
        total++; if ({irr, src_id} !== {1'b1, 2'd2}) begin bad++; $display("FAIL ack_edge_reserve got irr=%b id=%0d exp irr=1 id=2", irr, src_id); end
        pulse_ack();
        pulse_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            total++;
            if ({irr, busy, src_id, intr_vec, pending} !== {m_irr, m_busy, m_id, m_vec, m_pend}) begin
                bad++;
                $display("FAIL rand_cycle%0d got irr=%b busy=%b id=%0d vec=%h pend=%b exp irr=%b busy=%b id=%0d vec=%h pend=%b",
                         n, irr, busy, src_id, intr_vec, pending, m_irr, m_busy, m_id, m_vec, m_pend);
            end
            if ($urandom_range(0, 2) == 0) irq_src = 4'($urandom_range(0, 15));
            intr_en    = ($urandom_range(0, 7) != 0);
            ack        = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 11) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            tick();
        end
        ack = 1'b0;
        eoi = 1'b0;
        mask_we = 1'b0;
        irq_src = 4'b0000;
        intr_en = 1'b1;
        repeat (2) tick();
        pulse_eoi();
        mask_we = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        // Drain anything still pending so the next scenario starts idle.
        repeat (6) begin
            if (irr) pulse_ack();
            if (busy) pulse_eoi();
            tick();
        end
    endtask

    task automatic test_reset_mid_serv();
        irq_src = 4'b1010;
        tick();
        tick();
        pulse_ack();
        irq_src = 4'b1000;
        tick();
        irq_src = 4'b1010;
        tick();
        total++; if ({busy, pending} !== {1'b1, 4'b1010}) begin bad++; $display("FAIL rst_setup got busy=%b pend=%b exp busy=1 pend=1010", busy, pending); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({irr, busy, src_id, intr_vec, pending} !== {1'b0, 1'b0, 2'd0, VB, 4'b0000}) begin
            bad++; $display("FAIL rst_async got irr=%b busy=%b id=%0d vec=%h pend=%b exp irr=0 busy=0 id=0 vec=%h pend=0000",
                            irr, busy, src_id, intr_vec, pending, VB);
        end
        irq_src = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if ({irr, busy, pending} !== {m_irr, m_busy, m_pend}) begin
            bad++; $display("FAIL rst_after got irr=%b busy=%b pend=%b exp irr=%b busy=%b pend=%b", irr, busy, pending, m_irr, m_busy, m_pend);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_intr_en_drop();
        test_ack_edge();
        test_random();
        test_reset_mid_serv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
